// File: rtl/param_seq_fsm_pkg.sv
// Shared definitions for the parametrised sequencer: sizing helper, legal
// state-count range, the per-cycle action encoding and a debug label function.
package seq_fsm_pkg;

    localparam int NUM_STATES_MIN = 2;
    localparam int NUM_STATES_MAX = 16;
    localparam int IDX_ZERO       = 0;

    // Winning action for one cycle, already resolved by priority.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_ABORT,
        ACT_HOLD,
        ACT_TIMEOUT,
        ACT_STEP,
        ACT_WRAP,
        ACT_DONE
    } seq_action_e;

    // Index width for a given state count; never below one bit.
    function automatic int seq_clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

    // Human-readable label for waveform viewers; not used by synthesised logic.
    function automatic string state_name(input int idx);
        return $sformatf("SEQ_S%0d", idx);
    endfunction

endpackage

// File: rtl/param_seq_fsm_if.sv
// Control/status bundle between a sequencer client (master) and the
// sequencer itself (slave).
interface param_seq_fsm_if
    import seq_fsm_pkg::*;
#(
    parameter int NUM_STATES = 4,
    parameter int TIMEOUT_W  = 8
) ();

    localparam int IDX_W = seq_clog2(NUM_STATES);

    logic [NUM_STATES-1:0] advance;
    logic                  hold;
    logic                  abort;
    logic [TIMEOUT_W-1:0]  timeout_val;
    logic [IDX_W-1:0]      state_idx;
    logic [NUM_STATES-1:0] state_onehot;
    logic                  step_pulse;
    logic                  wrap_pulse;
    logic                  timeout_err;
    logic                  done;

    modport master (
        output advance, hold, abort, timeout_val,
        input  state_idx, state_onehot, step_pulse, wrap_pulse, timeout_err, done
    );

    modport slave (
        input  advance, hold, abort, timeout_val,
        output state_idx, state_onehot, step_pulse, wrap_pulse, timeout_err, done
    );

endinterface

// File: rtl/param_seq_fsm_dwell_timer.sv
// Per-state dwell counter: clears on state entry, freezes on hold, saturates,
// and flags when the programmed dwell limit is about to be reached.
module seq_dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         hold,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expire
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!hold && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A limit of zero disables the check; an already-passed limit never matches.
    assign expire = en && !hold && (limit != '0) && (cnt_q == (limit - W'(1)));

endmodule

// File: rtl/param_seq_fsm.sv
// Linear sequencer: steps through NUM_STATES states gated by per-state advance
// bits, with abort, hold, dwell timeout and ring/one-shot termination.
module param_seq_fsm
    import seq_fsm_pkg::*;
#(
    parameter int NUM_STATES = 4,
    parameter int TIMEOUT_W  = 8,
    parameter bit WRAP       = 1'b1
) (
    input logic             clk,
    input logic             reset,
    param_seq_fsm_if.slave  bus
);

    localparam int IDX_W = seq_clog2(NUM_STATES);
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(IDX_ZERO);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STATES - 1);

    if ((NUM_STATES < NUM_STATES_MIN) || (NUM_STATES > NUM_STATES_MAX)) begin : g_bad_num_states
        $error("param_seq_fsm: NUM_STATES out of range");
    end

    logic [IDX_W-1:0]      state_q, state_d;
    logic [NUM_STATES-1:0] onehot_q;
    logic                  step_q, step_d;
    logic                  wrap_q, wrap_d;
    logic                  terr_q, terr_d;
    logic                  done_q, done_d;
    logic                  dwell_clr;
    logic                  expire;
    seq_action_e           action;

    seq_dwell_timer #(.W(TIMEOUT_W)) u_dwell (
        .clk    (clk),
        .reset  (reset),
        .clr    (dwell_clr),
        .hold   (bus.hold),
        .en     (!done_q),
        .limit  (bus.timeout_val),
        .expire (expire)
    );

    // Resolve abort > hold > timeout > advance into a single action.
    always_comb begin
        action = ACT_NONE;
        if (bus.abort) begin
            action = ACT_ABORT;
        end else if (bus.hold) begin
            action = ACT_HOLD;
        end else if (expire) begin
            action = ACT_TIMEOUT;
        end else if (bus.advance[state_q]) begin
            if (state_q != LAST_IDX) begin
                action = ACT_STEP;
            end else if (WRAP) begin
                action = ACT_WRAP;
            end else if (!done_q) begin
                action = ACT_DONE;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        step_d    = 1'b0;
        wrap_d    = 1'b0;
        terr_d    = 1'b0;
        dwell_clr = 1'b0;
        case (action)
            ACT_ABORT: begin
                state_d   = FIRST_IDX;
                done_d    = 1'b0;
                dwell_clr = 1'b1;
            end
            ACT_TIMEOUT: begin
                state_d   = FIRST_IDX;
                terr_d    = 1'b1;
                dwell_clr = 1'b1;
            end
            ACT_STEP: begin
                state_d   = state_q + IDX_W'(1);
                step_d    = 1'b1;
                dwell_clr = 1'b1;
            end
            ACT_WRAP: begin
                state_d   = FIRST_IDX;
                step_d    = 1'b1;
                wrap_d    = 1'b1;
                dwell_clr = 1'b1;
            end
            ACT_DONE: begin
                done_d = 1'b1;
                step_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // One-hot is decoded from the next state so it lines up with state_idx.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FIRST_IDX;
            onehot_q <= NUM_STATES'(1);
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
            terr_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            onehot_q <= NUM_STATES'(1) << state_d;
            step_q   <= step_d;
            wrap_q   <= wrap_d;
            terr_q   <= terr_d;
            done_q   <= done_d;
        end
    end

    assign bus.state_idx    = state_q;
    assign bus.state_onehot = onehot_q;
    assign bus.step_pulse   = step_q;
    assign bus.wrap_pulse   = wrap_q;
    assign bus.timeout_err  = terr_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_param_seq_fsm.sv
// Directed bench for the sequencer: ring (4 states), one-shot (5 states) and
// the 16-state wrap corner, each with hand-computed expected values.
module tb_param_seq_fsm;

    logic clk;
    logic reset;
    int   testCount;
    int   failCount;

    param_seq_fsm_if #(.NUM_STATES(4),  .TIMEOUT_W(8)) ifA ();
    param_seq_fsm_if #(.NUM_STATES(5),  .TIMEOUT_W(8)) ifB ();
    param_seq_fsm_if #(.NUM_STATES(16), .TIMEOUT_W(8)) ifC ();

    param_seq_fsm #(.NUM_STATES(4),  .TIMEOUT_W(8), .WRAP(1'b1)) dutA (.clk(clk), .reset(reset), .bus(ifA.slave));
    param_seq_fsm #(.NUM_STATES(5),  .TIMEOUT_W(8), .WRAP(1'b0)) dutB (.clk(clk), .reset(reset), .bus(ifB.slave));
    param_seq_fsm #(.NUM_STATES(16), .TIMEOUT_W(8), .WRAP(1'b1)) dutC (.clk(clk), .reset(reset), .bus(ifC.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; results are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the inputs of one sequencer instance (0 = A, 1 = B, 2 = C).
    task automatic applyStimulus(input int dut, input logic [15:0] adv, input logic hold,
                                 input logic abort, input logic [7:0] tval);
        case (dut)
            0: begin
                ifA.advance = adv[3:0]; ifA.hold = hold; ifA.abort = abort; ifA.timeout_val = tval;
            end
            1: begin
                ifB.advance = adv[4:0]; ifB.hold = hold; ifB.abort = abort; ifB.timeout_val = tval;
            end
            default: begin
                ifC.advance = adv; ifC.hold = hold; ifC.abort = abort; ifC.timeout_val = tval;
            end
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        int wrapCount;
        int stepCount;
        testCount = 0;
        failCount = 0;
        reset = 1'b1;
        applyStimulus(0, 16'h0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1, 16'h0, 1'b0, 1'b0, 8'd0);
        applyStimulus(2, 16'h0, 1'b0, 1'b0, 8'd0);
        tick();
        tick();
        reset = 1'b0;

        checkOutput("rst_idx",    32'(ifA.state_idx),    32'd0);
        checkOutput("rst_onehot", 32'(ifA.state_onehot), 32'h1);
        checkOutput("rst_step",   32'(ifA.step_pulse),   32'd0);
        checkOutput("rst_wrap",   32'(ifA.wrap_pulse),   32'd0);
        checkOutput("rst_terr",   32'(ifA.timeout_err),  32'd0);
        checkOutput("rst_done",   32'(ifB.done),         32'd0);

        // Ring walk 0->1->2->3->0 with exactly one wrap pulse.
        wrapCount = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 16'(1 << i), 1'b0, 1'b0, 8'd0);
            tick();
            checkOutput($sformatf("ring_idx%0d", i),    32'(ifA.state_idx),    32'((i + 1) % 4));
            checkOutput($sformatf("ring_onehot%0d", i), 32'(ifA.state_onehot), 32'(1 << ((i + 1) % 4)));
            checkOutput($sformatf("ring_step%0d", i),   32'(ifA.step_pulse),   32'd1);
            if (ifA.wrap_pulse) wrapCount++;
        end
        checkOutput("ring_wrap_once", 32'(wrapCount), 32'd1);
        applyStimulus(0, 16'h0, 1'b0, 1'b0, 8'd0);
        tick();
        checkOutput("ring_step_clear", 32'(ifA.step_pulse), 32'd0);

        // Advance bits for other states are ignored.
        applyStimulus(0, 16'hE, 1'b0, 1'b0, 8'd0);
        tick();
        checkOutput("ignore_idx",  32'(ifA.state_idx),  32'd0);
        checkOutput("ignore_step", 32'(ifA.step_pulse), 32'd0);

        // One-shot: walk to the last state, then hold its advance for 5 cycles.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 16'(1 << i), 1'b0, 1'b0, 8'd0);
            tick();
            checkOutput($sformatf("os_idx%0d", i), 32'(ifB.state_idx), 32'(i + 1));
        end
        stepCount = 0;
        applyStimulus(1, 16'h10, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ifB.step_pulse) stepCount++;
            checkOutput($sformatf("os_last_idx%0d", i), 32'(ifB.state_idx), 32'd4);
            checkOutput($sformatf("os_done%0d", i),     32'(ifB.done),      32'd1);
        end
        checkOutput("os_single_step", 32'(stepCount), 32'd1);

        // Abort beats advance in the last state and clears done.
        applyStimulus(1, 16'h10, 1'b0, 1'b1, 8'd0);
        tick();
        checkOutput("abort_idx",    32'(ifB.state_idx),    32'd0);
        checkOutput("abort_onehot", 32'(ifB.state_onehot), 32'h1);
        checkOutput("abort_done",   32'(ifB.done),         32'd0);
        checkOutput("abort_step",   32'(ifB.step_pulse),   32'd0);
        applyStimulus(1, 16'h0, 1'b0, 1'b0, 8'd0);

        // Timeout of 3 in state 0: error pulse every third cycle.
        applyStimulus(0, 16'h0, 1'b0, 1'b1, 8'd0);
        tick();
        applyStimulus(0, 16'h0, 1'b0, 1'b0, 8'd3);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("to_s0_terr%0d", i), 32'(ifA.timeout_err), 32'((i % 3) == 2));
            checkOutput($sformatf("to_s0_idx%0d", i),  32'(ifA.state_idx),   32'd0);
        end

        // Timeout beats an advance landing on the expiry cycle in state 2.
        applyStimulus(0, 16'h1, 1'b0, 1'b0, 8'd3);
        tick();
        applyStimulus(0, 16'h2, 1'b0, 1'b0, 8'd3);
        tick();
        checkOutput("to_s2_enter", 32'(ifA.state_idx), 32'd2);
        applyStimulus(0, 16'h0, 1'b0, 1'b0, 8'd3);
        tick();
        tick();
        checkOutput("to_s2_wait", 32'(ifA.state_idx), 32'd2);
        applyStimulus(0, 16'h4, 1'b0, 1'b0, 8'd3);
        tick();
        checkOutput("to_beat_idx",  32'(ifA.state_idx),   32'd0);
        checkOutput("to_beat_terr", 32'(ifA.timeout_err), 32'd1);
        checkOutput("to_beat_step", 32'(ifA.step_pulse),  32'd0);

        // Hold in state 1 with advance high and timeout 4: frozen for 10 cycles.
        applyStimulus(0, 16'h1, 1'b0, 1'b0, 8'd4);
        tick();
        checkOutput("hold_enter", 32'(ifA.state_idx), 32'd1);
        applyStimulus(0, 16'h2, 1'b1, 1'b0, 8'd4);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("hold_idx%0d", i),  32'(ifA.state_idx),   32'd1);
            checkOutput($sformatf("hold_step%0d", i), 32'(ifA.step_pulse),  32'd0);
            checkOutput($sformatf("hold_terr%0d", i), 32'(ifA.timeout_err), 32'd0);
        end
        applyStimulus(0, 16'h2, 1'b0, 1'b0, 8'd4);
        tick();
        checkOutput("hold_release_idx",  32'(ifA.state_idx),  32'd2);
        checkOutput("hold_release_step", 32'(ifA.step_pulse), 32'd1);

        // Reset mid-sequence in state 2 after five dwell cycles.
        applyStimulus(0, 16'h0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) tick();
        applyStimulus(0, 16'h4, 1'b0, 1'b0, 8'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid_rst_idx",    32'(ifA.state_idx),    32'd0);
        checkOutput("mid_rst_onehot", 32'(ifA.state_onehot), 32'h1);
        checkOutput("mid_rst_step",   32'(ifA.step_pulse),   32'd0);
        // A cleared dwell counter lets a limit of 3 fire on the third cycle.
        applyStimulus(0, 16'h0, 1'b0, 1'b0, 8'd3);
        tick();
        tick();
        checkOutput("mid_rst_dwell_early", 32'(ifA.timeout_err), 32'd0);
        tick();
        checkOutput("mid_rst_dwell_fire", 32'(ifA.timeout_err), 32'd1);
        applyStimulus(0, 16'h0, 1'b0, 1'b0, 8'd0);

        // Sixteen-state ring: index 15 wraps to 0.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(2, 16'(1 << i), 1'b0, 1'b0, 8'd0);
            tick();
            checkOutput($sformatf("c16_idx%0d", i),    32'(ifC.state_idx),    32'((i + 1) % 16));
            checkOutput($sformatf("c16_onehot%0d", i), 32'(ifC.state_onehot), 32'(1 << ((i + 1) % 16)));
            checkOutput($sformatf("c16_wrap%0d", i),   32'(ifC.wrap_pulse),   32'(i == 15));
        end
        applyStimulus(2, 16'h0, 1'b0, 1'b0, 8'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
